fp_operand_loader: RTL and testbench

Byte-serial operand loader feeding the single-precision floating-point multiplier. It assembles two 32-bit IEEE-754 operands (A, then B) from an 8-bit valid/ready input stream, MSB byte first. It then holds the pair stable on `dataA`/`dataB` with `out_valid` until the downstream stage accepts it. It sits between the board/host byte source and the combinational multiplier unit, whose inputs it drives directly.

---
 rtl/fp_loader_pkg.sv | 31 +++
 rtl/fp_classify.sv | 20 ++
 rtl/fp_operand_loader.sv | 115 +++++++++++
 tb/tb_fp_operand_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_loader_pkg.sv
// Shared types and constants for the byte-serial FP operand loader.
package fp_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        FP_NORMAL = 2'd0,
        FP_ZERO   = 2'd1,
        FP_INF    = 2'd2,
        FP_NAN    = 2'd3
    } fp_class_e;

    localparam logic [7:0]  EXP_MAX        = 8'hFF;
    localparam int unsigned EXP_BIAS       = 127;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Denormals are reported as zero because the multiplier flushes them.
    function automatic fp_class_e fp_class_of(input logic [7:0] exp, input logic [22:0] frac);
        if (exp == 8'h00) begin
            return FP_ZERO;
        end else if (exp == EXP_MAX) begin
            return (frac == 23'd0) ? FP_INF : FP_NAN;
        end
        return FP_NORMAL;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier (sign ignored).
module fp_classify
    import fp_loader_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [1:0]  cls_o
);

    logic      unused_sign;
    fp_class_e cls;

    assign unused_sign = word_i[31];

    always_comb begin
        cls = fp_class_of(word_i[30:23], word_i[22:0]);
    end

    assign cls_o = cls;

endmodule

// File: rtl/fp_operand_loader.sv
// Assembles operand pairs A/B from an MSB-first byte stream and holds them for the multiplier.
// Optional macro OPERAND_CLASS_EN adds registered classA/classB outputs.
module fp_operand_loader
    import fp_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  pair_count
`ifdef OPERAND_CLASS_EN
    ,
    output logic [1:0]  classA,
    output logic [1:0]  classB
`endif
);

    localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [31:0] data_a_q;
    logic [31:0] data_b_q;
    logic        out_valid_q;
    logic [7:0]  pair_count_q;
    logic        accept;
    logic [31:0] data_b_next;

    assign in_ready    = (state_q != HOLD);
    assign accept      = in_valid && in_ready;
    assign data_b_next = {data_b_q[23:0], in_data};

`ifdef OPERAND_CLASS_EN
    logic [1:0] class_a_q;
    logic [1:0] class_b_q;
    logic [1:0] class_a_next;
    logic [1:0] class_b_next;

    // B is classified from its completed value, including the byte arriving this edge.
    fp_classify u_classify_a (
        .word_i (data_a_q),
        .cls_o  (class_a_next)
    );

    fp_classify u_classify_b (
        .word_i (data_b_next),
        .cls_o  (class_b_next)
    );

    assign classA = class_a_q;
    assign classB = class_b_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD_A;
            idx_q        <= 2'd0;
            data_a_q     <= 32'd0;
            data_b_q     <= 32'd0;
            out_valid_q  <= 1'b0;
            pair_count_q <= 8'd0;
`ifdef OPERAND_CLASS_EN
            class_a_q    <= 2'd0;
            class_b_q    <= 2'd0;
`endif
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        data_a_q <= {data_a_q[23:0], in_data};
                        idx_q    <= idx_q + 2'd1;
                        if (idx_q == LastIdx) begin
                            state_q <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        data_b_q <= data_b_next;
                        idx_q    <= idx_q + 2'd1;
                        if (idx_q == LastIdx) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
`ifdef OPERAND_CLASS_EN
                            class_a_q   <= class_a_next;
                            class_b_q   <= class_b_next;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        pair_count_q <= pair_count_q + 8'd1;
                        state_q      <= LOAD_A;
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

    assign dataA      = data_a_q;
    assign dataB      = data_b_q;
    assign out_valid  = out_valid_q;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed self-checking bench for fp_operand_loader (class checks only with OPERAND_CLASS_EN).
module tb_fp_operand_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pair_count;
`ifdef OPERAND_CLASS_EN
    logic [1:0]  classA;
    logic [1:0]  classB;
`endif

    int checks   = 0;
    int failures = 0;

    fp_operand_loader u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dataA      (dataA),
        .dataB      (dataB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pair_count (pair_count)
`ifdef OPERAND_CLASS_EN
        ,
        .classA     (classA),
        .classB     (classB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one byte and hold it until accepted, bounded.
    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_pair(input logic [31:0] a, input logic [31:0] b, input int max_gap);
        logic [63:0] w;
        int gap;
        w = {a, b};
        for (int i = 0; i < 8; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            push(w[63 - 8*i -: 8]);
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        do_reset();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_dataA", dataA, 32'd0);
        check("rst_dataB", dataB, 32'd0);
        check("rst_pair_count", {24'd0, pair_count}, 32'd0);

        // Basic load, out_ready held high.
        out_ready = 1'b1;
        load_pair(32'h3FC0_0000, 32'h4000_0000, 0);
        check("basic_valid", {31'd0, out_valid}, 32'd1);
        check("basic_dataA", dataA, 32'h3FC0_0000);
        check("basic_dataB", dataB, 32'h4000_0000);
        check("basic_hold_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("basic_valid_drop", {31'd0, out_valid}, 32'd0);
        check("basic_count", {24'd0, pair_count}, 32'd1);
        check("basic_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Backpressure with junk bytes offered during HOLD.
        load_pair(32'h3F80_0000, 32'h4040_0000, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hA5 + 8'(c);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_dataA", dataA, 32'h3F80_0000);
            check("bp_dataB", dataB, 32'h4040_0000);
        end
        in_valid = 1'b0;
        handoff();
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_count", {24'd0, pair_count}, 32'd2);
        load_pair(32'hC120_0000, 32'h3E80_0000, 0);
        check("bp_next_dataA", dataA, 32'hC120_0000);
        check("bp_next_dataB", dataB, 32'h3E80_0000);
        check("bp_one_handoff", {24'd0, pair_count}, 32'd2);
        handoff();
        check("bp_count2", {24'd0, pair_count}, 32'd3);

        // Reset part-way through B.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77);
        do_reset();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_dataA", dataA, 32'd0);
        check("mid_rst_dataB", dataB, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_count", {24'd0, pair_count}, 32'd0);
        load_pair(32'h4040_0000, 32'hC080_0000, 0);
        check("mid_rst_load_valid", {31'd0, out_valid}, 32'd1);
        check("mid_rst_load_dataA", dataA, 32'h4040_0000);
        check("mid_rst_load_dataB", dataB, 32'hC080_0000);
        handoff();

        // Random idle gaps between bytes; out_valid must not rise early.
        push(8'h3F); push(8'hC0); push(8'h00); push(8'h00);
        push(8'h40); push(8'h00);
        for (int g = 0; g < 3; g++) @(negedge clk);
        push(8'h00);
        check("gap_early_valid", {31'd0, out_valid}, 32'd0);
        push(8'h00);
        check("gap_valid", {31'd0, out_valid}, 32'd1);
        check("gap_dataA", dataA, 32'h3FC0_0000);
        check("gap_dataB", dataB, 32'h4000_0000);
        handoff();
        load_pair(32'h4049_0FDB, 32'hBF00_0000, 3);
        check("gap_rand_dataA", dataA, 32'h4049_0FDB);
        check("gap_rand_dataB", dataB, 32'hBF00_0000);
        check("gap_rand_count", {24'd0, pair_count}, 32'd2);
        handoff();
        check("gap_rand_count2", {24'd0, pair_count}, 32'd3);

        // 256 hand-offs wrap the counter back to zero.
        do_reset();
        for (int p = 0; p < 255; p++) begin
            load_pair(32'(p), 32'(p + 1), 0);
            handoff();
        end
        check("wrap_255", {24'd0, pair_count}, 32'd255);
        load_pair(32'h0000_00FF, 32'h0000_0100, 0);
        check("wrap_last_dataA", dataA, 32'h0000_00FF);
        handoff();
        check("wrap_0", {24'd0, pair_count}, 32'd0);

`ifdef OPERAND_CLASS_EN
        load_pair(32'h7F80_0000, 32'h7FC0_0000, 0);
        check("class_a_inf", {30'd0, classA}, 32'd2);
        check("class_b_nan", {30'd0, classB}, 32'd3);
        handoff();
        load_pair(32'h0000_0001, 32'h3F80_0000, 0);
        check("class_a_zero", {30'd0, classA}, 32'd1);
        check("class_b_normal", {30'd0, classB}, 32'd0);
        handoff();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
